sd_spi_master: RTL and testbench

Byte-oriented SPI master (mode 0) that drives the SD-card SPI lines `sd_cs`, `sd_sck` and `sd_sdi`, and samples `sd_sdo`. It is the host end of the link whose device end is the emulated `sd_card` responder. It sits between the CPU I/O port logic and the SD signals. Each start command shifts out one byte and captures one byte, at a slow (initialisation) or fast SCK rate, with software-controlled chip select.

---
 rtl/sd_spi_master.sv | 112 +++++++++++
 tb/tb_sd_spi_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master.sv
`timescale 1ns/1ps
// Byte-wide SPI mode-0 master for the SD card link: one start shifts a byte out on sd_sdi
// and captures one byte from sd_sdo, at a slow or fast SCK rate, with software chip select.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer; cs_set and start accepted, sck low, sdi high
// ST_LOW   | sck low phase; sdi holds current bit, counts down H cycles
// ST_HIGH  | sck high phase; counts down H cycles, then next bit or end
module sd_spi_master #(
  parameter int unsigned DIV_SLOW = 31,
  parameter int unsigned DIV_FAST = 0
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       speed,
  input  logic       cs_set,
  input  logic       cs_val,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sd_cs,
  output logic       sd_sck,
  output logic       sd_sdi,
  input  logic       sd_sdo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [7:0] W_DIV_SLOW = 8'(DIV_SLOW);
  localparam logic [7:0] W_DIV_FAST = 8'(DIV_FAST);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic [7:0] w_div;

  assign w_div = speed ? W_DIV_FAST : W_DIV_SLOW;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_div   <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= 8'hFF;
      sd_cs   <= 1'b1;
      sd_sck  <= 1'b0;
      sd_sdi  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cs_set) sd_cs <= cs_val;
          if (start) begin
            r_shift <= tx_data;
            r_div   <= w_div;
            r_cnt   <= w_div;
            r_bit   <= 3'd0;
            sd_sdi  <= tx_data[7];
            busy    <= 1'b1;
            r_state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (r_cnt == 8'd0) begin
            // Card output has been stable for a full half-period; sample on the rising edge.
            sd_sck  <= 1'b1;
            r_shift <= {r_shift[6:0], sd_sdo};
            r_cnt   <= r_div;
            r_state <= ST_HIGH;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_HIGH: begin
          if (r_cnt == 8'd0) begin
            sd_sck <= 1'b0;
            r_cnt  <= r_div;
            if (r_bit != 3'd7) begin
              sd_sdi  <= r_shift[7];
              r_bit   <= r_bit + 3'd1;
              r_state <= ST_LOW;
            end else begin
              sd_sdi  <= 1'b1;
              rx_data <= r_shift;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_bit   <= 3'd0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
`timescale 1ns/1ps
// Directed bench for sd_spi_master: loopback and a simple card model on sd_sdo,
// checking SCK edge timing, MOSI bit order, done latency, rx_data and chip select.
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       speed = 1'b0;
  logic       cs_set = 1'b0;
  logic       cs_val = 1'b1;
  logic       sd_sdo;
  logic       busy, done, sd_cs, sd_sck, sd_sdi;
  logic [7:0] rx_data;

  logic       loop = 1'b1;
  logic [7:0] card_byte = 8'hFF;
  int         nfall = 0;
  int         card_base = 0;
  int         card_k;
  logic       card_bit;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  logic cs0;

  sd_spi_master #(.DIV_SLOW(3), .DIV_FAST(0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .tx_data(tx_data),
    .speed(speed), .cs_set(cs_set), .cs_val(cs_val), .busy(busy), .done(done),
    .rx_data(rx_data), .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_sdi(sd_sdi), .sd_sdo(sd_sdo)
  );

  always #5 clk_sys = ~clk_sys;

  // Card model: presents card_byte MSB first, advancing one bit on each SCK fall.
  always @(negedge sd_sck) nfall++;
  always_comb begin
    card_k   = nfall - card_base;
    card_bit = 1'b1;
    if (card_k >= 0 && card_k < 8) card_bit = card_byte[3'(7 - card_k)];
  end
  assign sd_sdo = loop ? sd_sdi : card_bit;

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_cs"}, sd_cs, 1);
    chk({pfx, "_sck"}, sd_sck, 0);
    chk({pfx, "_sdi"}, sd_sdi, 1);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_rx"}, rx_data, 8'hFF);
  endtask

  task automatic set_cs(input logic v);
    cs_set = 1'b1;
    cs_val = v;
    tick();
    cs_set = 1'b0;
    chk("cs_set", sd_cs, v);
  endtask

  // Issues start now (edge 0 is the next edge) and follows the byte until done.
  // poke > 0 pulses start/cs_set with junk data for edge number poke.
  task automatic xfer(input logic [7:0] tx, input logic spd, input int h,
                      input logic [7:0] exp_rx, input int poke);
    int edges, bad, done_at, csbad;
    logic prev;
    logic [7:0] mosi;
    edges = 0; bad = 0; done_at = -1; csbad = 0; prev = 1'b0; mosi = 8'h00;
    tx_data = tx;
    speed   = spd;
    start   = 1'b1;
    tick();
    start     = 1'b0;
    cs_set    = 1'b0;
    tx_data   = ~tx;
    speed     = ~spd;
    start_cyc = cyc;
    cs0       = sd_cs;
    chk("busy_start", busy, 1);
    chk("mosi_b7_start", sd_sdi, tx[7]);
    for (int n = 1; n <= 16 * h + 8; n++) begin
      if (n == poke) begin
        start = 1'b1; cs_set = 1'b1; cs_val = ~cs0; tx_data = 8'h00;
      end else if (poke > 0 && n == poke + 1) begin
        start = 1'b0; cs_set = 1'b0;
      end
      tick();
      if (sd_cs !== cs0) csbad++;
      if (sd_sck !== prev) begin
        edges++;
        if (n != edges * h) bad++;
        if (sd_sck) mosi = {mosi[6:0], sd_sdi};
        prev = sd_sck;
      end
      if (done) begin
        done_at = n;
        break;
      end
    end
    start  = 1'b0;
    cs_set = 1'b0;
    done_cyc = cyc;
    chk("sck_edges", edges, 16);
    chk("sck_edge_timing_bad", bad, 0);
    chk("mosi_bits", mosi, tx);
    chk("done_latency", done_at, 16 * h);
    chk("rx_data", rx_data, exp_rx);
    chk("busy_end", busy, 0);
    chk("sck_end", sd_sck, 0);
    chk("sdi_end", sd_sdi, 1);
    chk("cs_stable", csbad, 0);
  endtask

  initial begin
    int busy_cnt, done_cnt, rises, first_done;
    logic prev;

    // 1. reset
    reset_n = 1'b0;
    tick(); tick();
    check_reset("reset");
    reset_n = 1'b1;
    tick();

    // 2. fast loopback, speed flipped mid-byte must not matter
    loop = 1'b1;
    set_cs(1'b0);
    xfer(8'hA5, 1'b1, 1, 8'hA5, 0);
    chk("cs_low_fast", sd_cs, 0);
    tick();
    chk("done_one_cycle", done, 0);

    // 3. slow mode against the card model
    loop = 1'b0;
    card_byte = 8'hC3;
    card_base = nfall;
    xfer(8'h3C, 1'b0, 4, 8'hC3, 0);
    tick();
    chk("rx_hold", rx_data, 8'hC3);

    // 4. requests while busy are ignored; idle start+cs_set take effect together
    loop = 1'b1;
    xfer(8'h69, 1'b1, 1, 8'h69, 5);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("no_second_xfer", busy_cnt, 0);
    chk("cs_after_ignored", sd_cs, 0);
    set_cs(1'b1);
    cs_set = 1'b1;
    cs_val = 1'b0;
    xfer(8'h81, 1'b1, 1, 8'h81, 0);
    chk("cs_same_edge", cs0, 0);

    // 5. reset mid-transfer
    tx_data = 8'hC5; speed = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 40 && rises < 3; i++) begin
      tick();
      if (sd_sck && !prev) rises++;
      prev = sd_sck;
    end
    chk("pre_reset_rises", rises, 3);
    reset_n = 1'b0;
    tick();
    check_reset("midreset");
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("no_done_after_reset", done_cnt, 0);
    set_cs(1'b0);
    xfer(8'h5A, 1'b1, 1, 8'h5A, 0);

    // 6. back-to-back: second start issued in the done cycle
    tick();
    xfer(8'hFF, 1'b1, 1, 8'hFF, 0);
    first_done = done_cyc;
    xfer(8'h01, 1'b1, 1, 8'h01, 0);
    chk("b2b_start_in_done_cycle", start_cyc, first_done + 1);
    chk("b2b_final_rx", rx_data, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
